count_snapshot_fifo: RTL and testbench

//  Downstream consumer of the free-running N-bit up-counter. Captures the counter value on each

---
 rtl/count_snapshot_fifo_pkg.sv | 11 +
 rtl/count_snapshot_fifo_if.sv | 21 ++
 rtl/count_snapshot_fifo_mem.sv | 52 +++++
 rtl/count_snapshot_fifo.sv | 84 ++++++++
 tb/tb_count_snapshot_fifo.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/count_snapshot_fifo_pkg.sv
// Shared constants and sizing helpers for the count snapshot FIFO.
// Optional drop counter is enabled by defining SNAP_DROP_CNT_EN.
package count_snap_pkg;
  localparam int DROP_CNT_W    = 8;
  localparam int DEFAULT_N     = 4;
  localparam int DEFAULT_DEPTH = 4;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/count_snapshot_fifo_if.sv
// Valid/ready snapshot read port between the FIFO head and its reader.
// Master drives data/valid, slave drives ready.
interface count_snapshot_fifo_if #(
  parameter int N = 4
);
  logic [N-1:0] snap_data;
  logic         snap_valid;
  logic         snap_ready;

  modport master (
    output snap_data,
    output snap_valid,
    input  snap_ready
  );

  modport slave (
    input  snap_data,
    input  snap_valid,
    output snap_ready
  );
endinterface

// File: rtl/count_snapshot_fifo_mem.sv
// Storage array, wrapping read/write pointers and registered level.
// Push/pop arrive already qualified by the top level.
module snap_fifo_mem
  import count_snap_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int LW    = level_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [N-1:0]  i_wdata,
  output logic [N-1:0]  o_rdata,
  output logic [LW-1:0] o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [N-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;
endmodule

// File: rtl/count_snapshot_fifo.sv
// Timestamps trigger pulses by capturing the upstream count into a FIFO.
// Define SNAP_DROP_CNT_EN to add the saturating drop_cnt output.
module count_snapshot_fifo
  import count_snap_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N-1:0]                count_in,
  input  logic                        trig,
  count_snapshot_fifo_if.master       snap,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic                        full,
  output logic                        empty,
  output logic                        overflow,
`ifdef SNAP_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0]       drop_cnt,
`endif
  input  logic                        ovf_clr
);
  localparam int LW = level_w(DEPTH);

  logic [LW-1:0] w_level;
  logic [N-1:0]  w_rdata;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          r_overflow;

  assign w_full  = (w_level == LW'(DEPTH));
  assign w_empty = (w_level == '0);
  assign w_pop   = !w_empty && snap.snap_ready;
  assign w_push  = trig && (!w_full || w_pop);
  assign w_drop  = trig && w_full && !w_pop;

  snap_fifo_mem #(
    .N     (N),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (count_in),
    .o_rdata (w_rdata),
    .o_level (w_level)
  );

  // A drop in the clearing cycle keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
    else if (ovf_clr) r_overflow <= 1'b0;
  end

`ifdef SNAP_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      if (ovf_clr)           r_drop_cnt <= DROP_CNT_W'(1);
      else if (~&r_drop_cnt) r_drop_cnt <= r_drop_cnt + 1'b1;
    end else if (ovf_clr) begin
      r_drop_cnt <= '0;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign snap.snap_data  = w_rdata;
  assign snap.snap_valid = !w_empty;
  assign level           = w_level;
  assign full            = w_full;
  assign empty           = w_empty;
  assign overflow        = r_overflow;
endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Scoreboard bench for count_snapshot_fifo (N=4, DEPTH=4).
// Define SNAP_DROP_CNT_EN to also exercise drop_cnt.
module tb_count_snapshot_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] count_in = '0;
  logic       trig = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [2:0] level;
  logic       full, empty, overflow;
`ifdef SNAP_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  count_snapshot_fifo_if #(.N(4)) sif ();

  count_snapshot_fifo #(.N(4), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .count_in (count_in),
    .trig     (trig),
    .snap     (sif),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
`ifdef SNAP_DROP_CNT_EN
    .drop_cnt (drop_cnt),
`endif
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int q[$];
  int mlev = 0;
  int movf = 0;
  int mdc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Monitor: a transfer happens on the coming edge when valid & ready
  always @(negedge clk) begin
    if (!rst && sif.snap_valid && sif.snap_ready) begin
      if (q.size() == 0) begin
        chk("pop_unexpected", 1, 0);
      end else begin
        chk("pop_data", int'(sif.snap_data), q.pop_front());
      end
    end
  end

  // One cycle: drive inputs, update model, step past the edge, check state
  task automatic step(input bit t, input int c, input bit r, input bit clr);
    bit pop, push, drop;
    trig = t;
    count_in = 4'(c);
    sif.snap_ready = r;
    ovf_clr = clr;
    pop  = (mlev > 0) && r;
    push = t && ((mlev < 4) || pop);
    drop = t && (mlev == 4) && !pop;
    if (push) q.push_back(c % 16);
    @(posedge clk);
    #1;
    mlev = mlev + int'(push) - int'(pop);
    if (drop) movf = 1;
    else if (clr) movf = 0;
    if (drop) mdc = clr ? 1 : ((mdc < 255) ? mdc + 1 : 255);
    else if (clr) mdc = 0;
    trig = 1'b0;
    sif.snap_ready = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic chk_state(input string nm);
    chk({nm, "_level"}, int'(level), mlev);
    chk({nm, "_full"}, int'(full), int'(mlev == 4));
    chk({nm, "_empty"}, int'(empty), int'(mlev == 0));
    chk({nm, "_valid"}, int'(sif.snap_valid), int'(mlev != 0));
    chk({nm, "_ovf"}, int'(overflow), movf);
  endtask

  task automatic drain(input string nm);
    int guard = 0;
    while (mlev > 0 && guard < 20) begin
      step(0, 0, 1, 0);
      guard++;
    end
    chk({nm, "_drained"}, mlev, 0);
    chk({nm, "_q_empty"}, q.size(), 0);
    chk_state(nm);
  endtask

  initial begin
    sif.snap_ready = 1'b0;
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_state("cold");
    chk("cold_data", int'(sif.snap_data), 0);

    // 1: async reset mid-stream
    step(1, 10, 0, 0);
    step(1, 11, 0, 0);
    step(1, 12, 0, 0);
    chk("pre_rst_level", int'(level), 3);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    mlev = 0;
    movf = 0;
    mdc = 0;
    chk("rst_empty", int'(empty), 1);
    chk("rst_valid", int'(sif.snap_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_data", int'(sif.snap_data), 0);
    chk("rst_ovf", int'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 2: single capture, then read
    step(1, 3, 0, 0);
    chk_state("t2_push");
    chk("t2_data", int'(sif.snap_data), 3);
    step(0, 0, 1, 0);
    chk_state("t2_pop");
    step(0, 0, 1, 0);
    chk_state("t2_ready_empty");

    // 3: fill, drop, drain, clear
    for (int i = 5; i <= 8; i++) step(1, i, 0, 0);
    chk_state("t3_full");
    step(1, 9, 0, 0);
    chk_state("t3_drop");
    chk("t3_ovf_set", int'(overflow), 1);
    drain("t3");
    step(0, 0, 0, 1);
    chk_state("t3_clr");

    // 4: push and pop while full
    for (int i = 5; i <= 8; i++) step(1, i, 0, 0);
    step(1, 9, 1, 0);
    chk_state("t4_pushpop");
    chk("t4_head", int'(sif.snap_data), 6);
    drain("t4");

    // 5: counter wrap with interleaved reads
    for (int i = 0; i < 10; i++)
      step(1, (14 + i) % 16, (i % 2 == 1) || (i >= 6), 0);
    chk_state("t5_mid");
    drain("t5");

`ifdef SNAP_DROP_CNT_EN
    // 6: saturating drop counter
    for (int i = 0; i < 4; i++) step(1, i, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 9, 0, 0);
    chk("t6_dc3", int'(drop_cnt), 3);
    step(0, 0, 0, 1);
    chk("t6_dc_clr", int'(drop_cnt), 0);
    chk_state("t6_clr");
    for (int i = 0; i < 300; i++) step(1, 9, 0, 0);
    chk("t6_dc_sat", int'(drop_cnt), 255);
    step(1, 9, 0, 1);
    chk("t6_dc_clr_drop", int'(drop_cnt), 1);
    chk("t6_model_dc", int'(drop_cnt), mdc);
    chk_state("t6_clr_drop");
    drain("t6");
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 want 1");
    $fatal(1, "timeout");
  end
endmodule
